display_scan_ctrl: RTL

Time-multiplexing scan controller for the 8-digit active-low seven-segment display. It holds a double-buffered frame of eight hex digits plus decimal points and rotates the digit select at a fixed refresh rate. A blanking gap between digits suppresses ghosting. It drives anode, segment and dp lines directly, and the UART datapath updates it through a single load strobe.

---
 rtl/display_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit active-low seven-segment display.
// Optional PWM dimming (brightness port) is built when DISPLAY_DIM_EN is defined.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_mask,
`ifdef DISPLAY_DIM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int DRIVE_CYCLES = REFRESH_DIV - BLANK_CYCLES;
  localparam int CNT_W        = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             wrap_s;

  logic [31:0] sh_digits_q, sh_digits_d, act_digits_q, act_digits_d;
  logic [7:0]  sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [7:0]  sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic        pending_q, pending_d;
`ifdef DISPLAY_DIM_EN
  logic [3:0]  sh_bright_q, sh_bright_d, act_bright_q, act_bright_d;
  logic [31:0] duty_s;
`endif

  logic [7:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       frame_done_q, frame_done_d;
  logic       on_s;

  // Scan state register: FSM state, slot cycle counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: BLANK then DRIVE within each slot, advance digit after DRIVE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = idx_q + 3'd1;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = 3'd0;
      end
    endcase
  end

  assign wrap_s = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST) && (idx_q == 3'd7);

  // Frame buffer registers: shadow written by load, active swapped at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits_q  <= 32'h0000_0000;
      sh_dp_q      <= 8'h00;
      sh_en_q      <= 8'h00;
      act_digits_q <= 32'h0000_0000;
      act_dp_q     <= 8'h00;
      act_en_q     <= 8'h00;
      pending_q    <= 1'b0;
`ifdef DISPLAY_DIM_EN
      sh_bright_q  <= 4'hF;
      act_bright_q <= 4'hF;
`endif
    end else begin
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pending_q    <= pending_d;
`ifdef DISPLAY_DIM_EN
      sh_bright_q  <= sh_bright_d;
      act_bright_q <= act_bright_d;
`endif
    end
  end

  // Frame update: a load on the boundary cycle bypasses the shadow straight to active.
  always_comb begin
    sh_digits_d  = sh_digits_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pending_d    = pending_q;
`ifdef DISPLAY_DIM_EN
    sh_bright_d  = sh_bright_q;
    act_bright_d = act_bright_q;
`endif
    if (load) begin
      sh_digits_d = digits_in;
      sh_dp_d     = dp_in;
      sh_en_d     = en_mask;
`ifdef DISPLAY_DIM_EN
      sh_bright_d = brightness;
`endif
    end else begin
      sh_digits_d = sh_digits_q;
    end
    if (wrap_s) begin
      pending_d = 1'b0;
      if (load) begin
        act_digits_d = digits_in;
        act_dp_d     = dp_in;
        act_en_d     = en_mask;
`ifdef DISPLAY_DIM_EN
        act_bright_d = brightness;
`endif
      end else if (pending_q) begin
        act_digits_d = sh_digits_q;
        act_dp_d     = sh_dp_q;
        act_en_d     = sh_en_q;
`ifdef DISPLAY_DIM_EN
        act_bright_d = sh_bright_q;
`endif
      end else begin
        act_digits_d = act_digits_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

`ifdef DISPLAY_DIM_EN
  assign duty_s = 32'((DRIVE_CYCLES * (int'(act_bright_d) + 1)) >> 4);
  assign on_s   = act_en_d[idx_d] && (32'(cnt_d) < duty_s);
`else
  assign on_s   = act_en_d[idx_d];
`endif

  // Output decode from the upcoming state so registered outputs track the FSM edge.
  always_comb begin
    anode_d      = 8'hFF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = (state_d == ST_DRIVE) && (idx_d == 3'd7) && (cnt_d == DRIVE_LAST);
    if (state_d == ST_DRIVE) begin
      seg_d = hex7(act_digits_d[{idx_d, 2'b00} +: 4]);
      dp_d  = ~act_dp_d[idx_d];
      if (on_s) begin
        anode_d = ~(8'd1 << idx_d);
      end else begin
        anode_d = 8'hFF;
      end
    end else begin
      anode_d = 8'hFF;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q      <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule
